// File: rtl/lte_fft_inc.sv
// Shared LTE framing constants: FFT size codes, CP base lengths, slot layout, counter widths.
package lte_fft_inc;

  localparam logic [2:0] FFT_2048 = 3'd0;
  localparam logic [2:0] FFT_1024 = 3'd1;
  localparam logic [2:0] FFT_512  = 3'd2;
  localparam logic [2:0] FFT_256  = 3'd3;
  localparam logic [2:0] FFT_128  = 3'd4;
  localparam int         FFT_MAX  = 2048;

  // CP lengths expressed at the 2048-point rate; scaled down by the FFT code shift.
  localparam int CP_NORM_FIRST = 160;
  localparam int CP_NORM       = 144;
  localparam int CP_EXT        = 512;

  localparam int SYMS_NORM = 7;
  localparam int SYMS_EXT  = 6;

  localparam int SAMP_W = 12;
  localparam int SYM_W  = 3;
  localparam int DIV_W  = 7;
  localparam int IQ_W   = 16;

  typedef logic [SAMP_W-1:0] samp_t;
  typedef logic [SYM_W-1:0]  sym_t;

  typedef struct packed {
    logic [2:0]       fft;
    logic             cp_ext;
    logic [DIV_W-1:0] ratio;
  } frm_cfg_t;

  function automatic logic [2:0] fft_clamp(input logic [2:0] code);
    return (code > FFT_128) ? FFT_128 : code;
  endfunction

  function automatic sym_t last_sym(input logic cp_ext);
    return cp_ext ? sym_t'(SYMS_EXT - 1) : sym_t'(SYMS_NORM - 1);
  endfunction

endpackage

// File: rtl/lte_cp_len.sv
// Combinational CP / symbol length lookup for a given FFT size, CP type and symbol index.
module lte_cp_len
  import lte_fft_inc::*;
(
  input  logic [2:0] fft_num,
  input  logic       cp_ext,
  input  sym_t       sym_idx,
  output samp_t      cp_len,
  output samp_t      sym_len
);

  samp_t base;
  samp_t n_len;

  // All base lengths are multiples of 16, so the shift is an exact N/2048 scale.
  always_comb begin
    if (cp_ext)               base = samp_t'(CP_EXT);
    else if (sym_idx == '0)   base = samp_t'(CP_NORM_FIRST);
    else                      base = samp_t'(CP_NORM);
    n_len   = samp_t'(FFT_MAX) >> fft_num;
    cp_len  = base >> fft_num;
    sym_len = cp_len + n_len;
  end

endmodule

// File: rtl/lte_sym_framer.sv
// LTE slot framer: paces upstream samples to the FFT port and flags symbol/slot starts.
module lte_sym_framer
  import lte_fft_inc::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic            En,
  input  logic [2:0]      FFT_num,
  input  logic [6:0]      FS_ratio,
  input  logic            CP_type,
  input  logic [IQ_W-1:0] Src_i,
  input  logic [IQ_W-1:0] Src_q,
  input  logic            Src_v,
  output logic            Src_rd,
  output logic [IQ_W-1:0] Dout_i,
  output logic [IQ_W-1:0] Dout_q,
  output logic            Dout_h,
  output logic            Dout_s,
  output logic            Dout_v,
  output logic            Udf_err,
  output logic            Cfg_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  frm_cfg_t         cfg_q, cfg_in;
  logic [DIV_W-1:0] div_cnt, div_inc, ratio_nxt;
  samp_t            samp_cnt, sym_len, cp_len_unused;
  sym_t             sym_cnt;
  logic             strobe, sym_end, slot_end, cfg_bad;

  always_comb begin
    cfg_in.fft    = fft_clamp(FFT_num);
    cfg_in.cp_ext = CP_type;
    cfg_in.ratio  = (FS_ratio == '0) ? DIV_W'(1) : FS_ratio;
  end

  assign cfg_bad = (FFT_num > FFT_128);

  lte_cp_len u_cp_len (
    .fft_num (cfg_q.fft),
    .cp_ext  (cfg_q.cp_ext),
    .sym_idx (sym_cnt),
    .cp_len  (cp_len_unused),
    .sym_len (sym_len)
  );

  assign strobe   = (state == S_RUN) && (div_cnt == '0);
  assign sym_end  = (samp_cnt == sym_len - samp_t'(1));
  assign slot_end = sym_end && (sym_cnt == last_sym(cfg_q.cp_ext));
  assign Src_rd   = strobe && Src_v && Reset;

  // A new ratio latched at the slot wrap must already govern the following divider step.
  always_comb begin
    ratio_nxt = (strobe && slot_end) ? cfg_in.ratio : cfg_q.ratio;
    div_inc   = div_cnt + 1'b1;
    if (div_inc >= ratio_nxt) div_inc = '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= S_IDLE;
      cfg_q    <= '0;
      div_cnt  <= '0;
      samp_cnt <= '0;
      sym_cnt  <= '0;
      Dout_i   <= '0;
      Dout_q   <= '0;
      Dout_h   <= 1'b0;
      Dout_s   <= 1'b0;
      Dout_v   <= 1'b0;
      Udf_err  <= 1'b0;
      Cfg_err  <= 1'b0;
    end else begin
      Dout_v <= strobe;
      Dout_h <= strobe && (samp_cnt == '0);
      Dout_s <= strobe && (samp_cnt == '0) && (sym_cnt == '0);
      Dout_i <= (strobe && Src_v) ? Src_i : '0;
      Dout_q <= (strobe && Src_v) ? Src_q : '0;
      if (strobe && !Src_v) Udf_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (En) begin
            state    <= S_RUN;
            cfg_q    <= cfg_in;
            div_cnt  <= '0;
            samp_cnt <= '0;
            sym_cnt  <= '0;
            if (cfg_bad) Cfg_err <= 1'b1;
          end
        end
        default: begin
          div_cnt <= div_inc;
          if (strobe) begin
            if (!sym_end) begin
              samp_cnt <= samp_cnt + 1'b1;
            end else begin
              samp_cnt <= '0;
              if (!slot_end) begin
                sym_cnt <= sym_cnt + 1'b1;
              end else begin
                sym_cnt <= '0;
                if (!En) begin
                  state   <= S_IDLE;
                  div_cnt <= '0;
                end else begin
                  cfg_q <= cfg_in;
                  if (cfg_bad) Cfg_err <= 1'b1;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/lte_sym_framer.md
LTE_SYM_FRAMER -- requirements
Module: lte_sym_framer

Interface
REQ-001 Clk  in  1  sole clock; all logic on rising edge.
REQ-002 Reset  in  1  synchronous, active-low reset.
REQ-003 En  in  1  1 = run framing; 0 = stop at the next slot boundary.
REQ-004 FFT_num  in  3  0-2048, 1-1024, 2-512, 3-256, 4-128; codes 5-7 are treated as 4 and set Cfg_err.
REQ-005 FS_ratio  in  7  clocks per output sample; 0 is treated as 1.
REQ-006 CP_type  in  1  0 normal CP, 1 extended CP.
REQ-007 Src_i, Src_q  in  16 each  sample from the upstream buffer, valid while Src_v=1.
REQ-008 Src_v  in  1  upstream has a sample available.
REQ-009 Src_rd  out  1  one-cycle pop strobe to upstream.
REQ-010 Dout_i, Dout_q  out  16 each  time-domain sample toward the FFT input port.
REQ-011 Dout_h  out  1  first sample of each OFDM symbol (first CP sample).
REQ-012 Dout_s  out  1  first sample of the 0.5 ms slot.
REQ-013 Dout_v  out  1  one-cycle sample strobe.
REQ-014 Udf_err, Cfg_err  out  1 each  sticky underflow and configuration error flags.

Function
REQ-015 The block SHALL have a two-state FSM: IDLE and RUN.
REQ-016 IDLE->RUN: on En=1; the first strobe occurs on the cycle after the transition.
REQ-017 RUN->IDLE: only after the last sample of a slot has been strobed with En=0; a partial slot is never emitted.
REQ-018 Divider: in RUN, a strobe fires every FS_ratio clocks; FS_ratio=1 gives a strobe every cycle.
REQ-019 N = 2048>>FFT_num.
REQ-020 Normal CP: 7 symbols per slot; symbol 0 CP = 160*N/2048, symbols 1-6 CP = 144*N/2048.
REQ-021 Extended CP: 6 symbols per slot, each with CP = 512*N/2048.
REQ-022 Every slot SHALL total 15360*N/2048 samples.
REQ-023 FFT_num, CP_type and FS_ratio SHALL be latched only on IDLE->RUN and at each slot wrap; mid-slot changes are ignored.
REQ-024 Sample counter: 12 bits, counts 0..CP+N-1, then wraps to 0 and advances the symbol counter.
REQ-025 Symbol counter: 3 bits, wraps to 0 after the last symbol of the slot.
REQ-026 On strobe cycle t, Src_rd = Src_v.
REQ-027 At t+1: Dout_v=1, Dout_i/q = the Src_i/q captured at t; one-cycle latency, registered outputs.
REQ-028 Underflow (strobe with Src_v=0): Dout_v still =1, Dout_i/q = 0, Udf_err set; the timing counters still advance.
REQ-029 Dout_h=1 with Dout_v when the sample counter was 0; Dout_s=1 when additionally the symbol counter was 0.
REQ-030 Dout_h and Dout_s SHALL be 0 whenever Dout_v=0.
REQ-031 Udf_err and Cfg_err SHALL clear only on reset.

Reset
REQ-032 While Reset=0 at a clock edge: FSM=IDLE, all counters=0, Src_rd=0, Dout_*=0, both error flags=0.
REQ-033 Reset mid-slot SHALL abort immediately; the first post-reset strobe starts a new slot with Dout_s=1.

Structure
REQ-034 The shared package (lte_fft_inc) SHALL hold:
- FFT_num codes and the 2048 maximum size;
- CP base lengths 160/144/512;
- symbols per slot 7/6;
- counter widths.
REQ-035 One sub-module, lte_cp_len, SHALL be combinational and map (FFT_num, CP_type, symbol index) to CP length and symbol length.

Verification
REQ-036 FFT_num=4, CP_type=0, FS_ratio=1, Src_v=1:
- Dout_h at sample offsets 0, 138, 275, ..., 823;
- Dout_s at 0 and 960;
- Dout_v continuous.
REQ-037 FFT_num=4, CP_type=1, FS_ratio=1: Dout_h every 160 samples, 6 per slot, Dout_s every 960.
REQ-038 FS_ratio=5, FFT_num=0, CP_type=0: Dout_v every 5th clock; Dout_s period 76800 clocks.
REQ-039 Src_v=0 for 3 strobes mid-symbol: 3 zero samples, Udf_err=1, next Dout_h position unchanged.
REQ-040 En dropped mid-slot: output continues to slot end, then IDLE with Dout_v=0; Reset=0 mid-slot: outputs 0 next cycle, restart begins with Dout_s=1.
REQ-041 FFT_num=6: Cfg_err=1, 128-point framing; CP_type toggled mid-slot takes effect only at the next Dout_s.
